// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, rstatus overflow codes and skid-buffer state encoding.
package alu_pkg;
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam int RSTAT_ADD  = 1;
  localparam int RSTAT_ADDI = 2;
  localparam int RSTAT_SUB  = 3;

  localparam int STATUS_REG_DEF = 30;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } skid_state_e;
endpackage

// File: rtl/alu_status_rewrite.sv
// Combinational rstatus rewrite: add/sub overflow redirects the write to the status register.
module alu_status_rewrite
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STATUS_REG = STATUS_REG_DEF
) (
  input  logic [4:0]       aluop,
  input  logic             is_addi,
  input  logic             overflow,
  input  logic [4:0]       rd,
  input  logic [WIDTH-1:0] result,
  output logic [4:0]       new_rd,
  output logic [WIDTH-1:0] new_result
);
  logic trap;

  assign trap = overflow && (aluop == ALU_ADD || aluop == ALU_SUB);

  always_comb begin
    new_rd     = rd;
    new_result = result;
    if (trap) begin
      new_rd = 5'(STATUS_REG);
      // addi outranks the opcode when picking the status code
      if (is_addi)                new_result = WIDTH'(RSTAT_ADDI);
      else if (aluop == ALU_ADD)  new_result = WIDTH'(RSTAT_ADD);
      else                        new_result = WIDTH'(RSTAT_SUB);
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage result buffer: two-entry skid buffer with rstatus rewrite and zero/neg flags.
// Optional RESULT_PARITY_EN adds a per-entry even-parity bit on out_parity.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STATUS_REG = STATUS_REG_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [4:0]       in_aluop,
  input  logic             in_is_addi,
  input  logic             in_overflow,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_zero,
`ifdef RESULT_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_neg
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [4:0]       rd;
`ifdef RESULT_PARITY_EN
    logic             parity;
`endif
  } entry_t;

  skid_state_e state, state_nxt;
  entry_t      main_q, skid_q, cap;
  logic        in_xfer, out_xfer;

  alu_status_rewrite #(.WIDTH(WIDTH), .STATUS_REG(STATUS_REG)) u_rewrite (
    .aluop      (in_aluop),
    .is_addi    (in_is_addi),
    .overflow   (in_overflow),
    .rd         (in_rd),
    .result     (in_result),
    .new_rd     (cap.rd),
    .new_result (cap.result)
  );
`ifdef RESULT_PARITY_EN
  assign cap.parity = ^cap.result;
`endif

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_xfer) state_nxt = ST_FULL1;
      ST_FULL1: begin
        if (in_xfer && !out_xfer)      state_nxt = ST_FULL2;
        else if (!in_xfer && out_xfer) state_nxt = ST_EMPTY;
      end
      ST_FULL2: if (out_xfer) state_nxt = ST_FULL1;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // ready comes only from the state register so the upstream path stays registered
  always_comb begin
    in_ready  = (state != ST_FULL2);
    out_valid = (state != ST_EMPTY);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (!flush) begin
      case (state)
        ST_EMPTY: if (in_xfer) main_q <= cap;
        ST_FULL1: begin
          if (in_xfer && out_xfer) main_q <= cap;
          else if (in_xfer)        skid_q <= cap;
        end
        ST_FULL2: if (out_xfer) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign out_result = main_q.result;
  assign out_rd     = main_q.rd;
  assign out_zero   = (main_q.result == '0);
  assign out_neg    = main_q.result[WIDTH-1];
`ifdef RESULT_PARITY_EN
  assign out_parity = main_q.parity;
`endif
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-stage output buffer directly downstream of the ALU bitwise/arith units; latches the 32-bit ALU result and forwards it to the memory stage.
- Generates zero/negative flags and applies the rstatus overflow rewrite (destination forced to $r30 with a status code).
- Two-entry skid buffer with a valid/ready handshake on both sides, so the upstream ready path is fully registered.

Parameters:
- WIDTH, 32, data path width of the result.
- STATUS_REG, 30, register index written on overflow.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous kill of all buffered entries (branch/jump redirect).
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_result  input  WIDTH  ALU result.
- in_aluop  input  5  ALU opcode (00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra).
- in_is_addi  input  1  instruction is addi.
- in_overflow  input  1  ALU overflow.
- in_rd  input  5  destination register.
- out_valid  output  1  downstream entry valid.
- out_ready  input  1  downstream accepts.
- out_result  output  WIDTH  forwarded result (possibly rstatus code).
- out_rd  output  5  forwarded destination.
- out_zero  output  1  out_result == 0.
- out_neg  output  1  out_result[WIDTH-1].

Behaviour:
- Transfer rule: a transfer occurs on a clock edge where valid && ready on that side. Once out_valid is high, it stays high and out_* stay stable until a downstream transfer.
- State machine (2 bits), with main and skid registers:
  - EMPTY: in transfer -> FULL1.
  - FULL1: input only -> FULL2; output only -> EMPTY; both -> FULL1 (main reloads).
  - FULL2: output transfer -> FULL1 (skid moves to main); no input is accepted.
- in_ready = (state != FULL2). It is taken from the state register, never from out_ready.
- Rewrite at capture time, before storing:
  - Condition: in_overflow && (aluop==00000 || aluop==00001).
  - Destination: rd := STATUS_REG.
  - Result: 1 for add, 2 for addi (takes precedence when in_is_addi), 3 for sub.
  - Overflow is ignored for every other opcode.
- Flags: out_zero and out_neg are computed combinationally from the main register (post-rewrite value).
- Latency: one cycle from input transfer to out_valid when EMPTY. Ordering is strictly FIFO.
- flush: next state EMPTY; an input offered in the same cycle is discarded.
- Reset (reset==0, sampled at clock edge) has priority over flush:
  - state EMPTY, out_valid 0, in_ready 1 in the following cycle;
  - out_result 0, out_rd 0, out_zero 1, out_neg 0.
  - A reset mid-handshake drops all entries.
- Data registers update only on a capture or shift, never while holding.

Optional Feature:
- Macro RESULT_PARITY_EN.
- When defined: adds output out_parity (1 bit) = even parity (XOR reduction) of out_result, stored per entry at capture; reset value 0.
- When undefined: the port and storage are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg: ALU opcode constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA), rstatus codes (RSTAT_ADD=1, RSTAT_ADDI=2, RSTAT_SUB=3), STATUS_REG default, and the skid-state encoding (ST_EMPTY, ST_FULL1, ST_FULL2).
- One natural sub-module: alu_status_rewrite, a combinational block that computes the rewritten rd and result from aluop, is_addi, overflow, rd and result.

Test Plan:
- Reset then single entry: reset=0 for 2 cycles, then in_result=0x0000_00F0, aluop=00010, rd=5, out_ready=1 -> out_valid next cycle, out_result=0x0000_00F0, out_rd=5, out_zero=0.
- Backpressure: out_ready=0, push 0x1 then 0x2 -> in_ready=0 after the second push; raise out_ready -> outputs 0x1, then 0x2 in order, with in_ready back to 1 one cycle after the first pop.
- Overflow rewrite: add with overflow, rd=7 -> out_rd=30, out_result=1; addi -> 2; sub -> 3; and-op with overflow=1, rd=7 -> out_rd=7 and result unchanged.
- Flags: in_result=0x0000_0000 -> out_zero=1; in_result=0x8000_0000 -> out_neg=1, out_zero=0.
- Flush in FULL2 with a simultaneous in_valid -> next cycle out_valid=0, in_ready=1, and no later emergence of the flushed entries.
- Reset mid-stream: assert reset=0 while in FULL2 -> next cycle out_valid=0, out_result=0, in_ready=1; with RESULT_PARITY_EN, result 0x7 gives out_parity=1 and result 0x3 gives out_parity=0.
